// File: rtl/updown_pkg.sv
// Shared types and helpers for the up/down display counter.
package updown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cnt_state_t;

  // Limit a requested load value to the top of the counting range.
  function automatic int unsigned clamp(input int unsigned value, input int unsigned max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/updown_counter_gen_bin2bcd.sv
// Combinational binary-to-BCD converter using the shift-and-add-3 method.
module bin2bcd #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
) (
  input  logic [WIDTH-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd
);

  logic [4*DIGITS-1:0] acc;

  // Shift the binary value in MSB first, correcting each digit before every shift.
  always_comb begin
    // NOTE: acc gets a value before the loop on every pass, so no latch can be inferred.
    acc = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (acc[4*d +: 4] >= 4'd5) acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      acc = {acc[4*DIGITS-2:0], bin[i]};
    end
    bcd = acc;
  end

endmodule

// File: rtl/updown_counter_gen.sv
// Up/down counter with a tick prescaler, a run/pause/done FSM, a clamped load,
// wrap-or-saturate bounds, a terminal-count pulse and a BCD view of the count.
module updown_counter_gen
  import updown_pkg::*;
#(
  parameter int MAX_COUNT = 99,
  parameter int WIDTH     = 7,
  parameter int PRESCALE  = 25_000_000,
  parameter int DIGITS    = 2
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                up_down,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_value,
  input  logic                wrap_en,
  output logic [WIDTH-1:0]    count,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                tc_pulse,
  output logic                running
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [WIDTH-1:0] max_val    = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] count_one  = WIDTH'(1);
  localparam logic [PW-1:0]    presc_last = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    presc_one  = PW'(1);

  cnt_state_t    state;
  logic [PW-1:0] presc;
  logic          tick;
  logic          at_bound;

  // A tick only happens in RUN when neither stop nor load outranks it this cycle.
  assign tick = (state == RUN) && (presc == presc_last) && !stop && !load;

  // Bound for the current direction; checked before any +/- so the count never overflows.
  assign at_bound = up_down ? (count == max_val) : (count == '0);

  // FSM, prescaler, count and terminal-count pulse; priority reset > load > stop > start > tick.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (reset) begin
      state    <= IDLE;
      running  <= 1'b0;
      presc    <= '0;
      count    <= '0;
      tc_pulse <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      if (load) begin
        count <= WIDTH'(clamp(32'(load_value), 32'(MAX_COUNT)));
        presc <= '0;
        if (state == DONE) begin
          state   <= PAUSE;
          running <= 1'b0;
        end
      end else begin
        unique case (state)
          IDLE, PAUSE: begin
            presc <= '0;
            if (start && !stop) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (stop) begin
              state   <= PAUSE;
              running <= 1'b0;
              presc   <= '0;
            end else if (tick) begin
              presc <= '0;
              if (!at_bound) begin
                count <= up_down ? count + count_one : count - count_one;
              end else begin
                tc_pulse <= 1'b1;
                if (wrap_en) begin
                  count <= up_down ? '0 : max_val;
                end else begin
                  state   <= DONE;
                  running <= 1'b0;
                end
              end
            end else begin
              presc <= presc + presc_one;
            end
          end
          DONE: begin
            presc <= '0;
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            presc   <= '0;
          end
        endcase
      end
    end
  end

  bin2bcd #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .bin (count),
    .bcd (bcd_out)
  );

endmodule

// File: tb/tb_updown_counter_gen.sv
// Directed bench for updown_counter_gen with PRESCALE=4, MAX_COUNT=99.
module tb_updown_counter_gen;

  localparam int WIDTH  = 7;
  localparam int DIGITS = 2;

  logic                Clk = 1'b0;
  logic                reset;
  logic                start;
  logic                stop;
  logic                up_down;
  logic                load;
  logic [WIDTH-1:0]    load_value;
  logic                wrap_en;
  logic [WIDTH-1:0]    count;
  logic [4*DIGITS-1:0] bcd_out;
  logic                tc_pulse;
  logic                running;

  int tests_run = 0;
  int tests_failed = 0;

  updown_counter_gen #(
    .MAX_COUNT (99),
    .WIDTH     (WIDTH),
    .PRESCALE  (4),
    .DIGITS    (DIGITS)
  ) dut (
    .Clk        (Clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .up_down    (up_down),
    .load       (load),
    .load_value (load_value),
    .wrap_en    (wrap_en),
    .count      (count),
    .bcd_out    (bcd_out),
    .tc_pulse   (tc_pulse),
    .running    (running)
  );

  always #5 Clk = ~Clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; up_down = 1'b1;
    load = 1'b0; load_value = '0; wrap_en = 1'b1;
    step(2);
    check("rst_count", int'(count), 0);
    check("rst_running", int'(running), 0);
    check("rst_tc", int'(tc_pulse), 0);
    check("rst_bcd", int'(bcd_out), 0);
    reset = 1'b0;

    // Count up from zero; ticks land 4, 8, 12 cycles after the RUN entry edge.
    start = 1'b1;
    step(1);
    check("run_entry_running", int'(running), 1);
    step(3);
    check("pre_tick_count", int'(count), 0);
    step(1);
    check("tick1_count", int'(count), 1);
    step(8);
    check("tick3_count", int'(count), 3);
    check("tick3_bcd", int'(bcd_out), 'h03);

    // Wrap up: 98 -> 99 -> 0 with a single-cycle tc_pulse -> 1.
    load = 1'b1; load_value = 7'd98;
    step(1);
    load = 1'b0;
    check("load98_count", int'(count), 98);
    check("load98_bcd", int'(bcd_out), 'h98);
    check("load98_running", int'(running), 1);
    step(4);
    check("up_99", int'(count), 99);
    check("up_99_tc", int'(tc_pulse), 0);
    step(4);
    check("wrap_0", int'(count), 0);
    check("wrap_tc", int'(tc_pulse), 1);
    step(1);
    check("wrap_tc_drop", int'(tc_pulse), 0);
    step(3);
    check("after_wrap_1", int'(count), 1);

    // Saturate down: 1 -> 0 -> held at 0 with tc_pulse, FSM in DONE.
    load = 1'b1; load_value = 7'd1; wrap_en = 1'b0; up_down = 1'b0;
    step(1);
    load = 1'b0;
    check("load1_count", int'(count), 1);
    step(4);
    check("down_0", int'(count), 0);
    check("down_0_tc", int'(tc_pulse), 0);
    step(4);
    check("sat_count", int'(count), 0);
    check("sat_tc", int'(tc_pulse), 1);
    check("sat_running", int'(running), 0);
    step(1);
    check("sat_tc_drop", int'(tc_pulse), 0);
    step(8);
    check("done_ignores_start", int'(running), 0);
    check("done_count_held", int'(count), 0);
    load = 1'b1; load_value = 7'd5;
    step(1);
    load = 1'b0;
    check("done_load_count", int'(count), 5);
    check("done_load_paused", int'(running), 0);
    step(1);
    check("pause_resume", int'(running), 1);
    step(4);
    check("resume_down_4", int'(count), 4);

    // stop and start together: stop wins, count frozen, prescaler cleared.
    up_down = 1'b1;
    step(2);
    stop = 1'b1;
    step(1);
    check("stop_wins", int'(running), 0);
    step(5);
    check("frozen_count", int'(count), 4);
    stop = 1'b0;
    step(1);
    check("release_running", int'(running), 1);
    step(3);
    check("release_no_early_tick", int'(count), 4);
    step(1);
    check("release_tick", int'(count), 5);

    // Oversized load clamps to 99; saturating up tick moves to DONE.
    load = 1'b1; load_value = 7'd120;
    step(1);
    load = 1'b0;
    check("clamp_count", int'(count), 99);
    check("clamp_bcd", int'(bcd_out), 'h99);
    step(4);
    check("sat_up_count", int'(count), 99);
    check("sat_up_tc", int'(tc_pulse), 1);
    check("sat_up_running", int'(running), 0);

    // Reset on the tick cycle at count 57 discards the pending tick.
    load = 1'b1; load_value = 7'd57;
    step(1);
    load = 1'b0;
    check("load57_bcd", int'(bcd_out), 'h57);
    step(1);
    check("load57_run", int'(running), 1);
    step(3);
    check("pre_reset_count", int'(count), 57);
    reset = 1'b1;
    step(1);
    check("midrun_rst_count", int'(count), 0);
    check("midrun_rst_running", int'(running), 0);
    check("midrun_rst_tc", int'(tc_pulse), 0);
    reset = 1'b0; start = 1'b0;
    step(8);
    check("idle_stays", int'(count), 0);
    check("idle_running", int'(running), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
